// File: rtl/md5_crack_sched.sv
// Brute-force MD5 search dispatcher: hands counter-suffixed candidates to a bank of
// iterative cores, watches returned digests for the target, drains and reports.
module md5_crack_sched #(
    parameter int CORES = 4,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [127:0]         target,
    input  logic [127:0]         base,
    input  logic [CNT_W-1:0]     limit,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [127:0]         match_value,
    output logic [CNT_W:0]       tested,
    output logic [127:0]         core_message,
    output logic [CORES-1:0]     core_new_message,
    input  logic [CORES-1:0]     core_valid,
    input  logic [CORES*128-1:0] core_digest,
    input  logic [CORES*128-1:0] core_value
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [127:0]       target_r;
    logic [127-CNT_W:0] base_hi;
    logic [CNT_W-1:0]   limit_r;
    logic [CNT_W-1:0]   cnt;
    logic               last_issued;
    logic [CORES-1:0]   pending;

    logic [CORES-1:0]   complete;
    logic [CORES-1:0]   match_mask;
    logic [CORES-1:0]   match_first;
    logic [CORES-1:0]   free;
    logic [CORES-1:0]   issue;
    logic [CNT_W:0]     n_complete;
    logic [127:0]       match_pick;
    logic               can_issue;
    logic               at_limit;

    // A core freed by a completion this cycle counts as free, so it can be reissued at once.
    always_comb begin
        complete   = pending & core_valid;
        match_mask = '0;
        n_complete = '0;
        match_pick = '0;
        for (int i = 0; i < CORES; i++) begin
            if (complete[i]) begin
                n_complete = n_complete + (CNT_W+1)'(1);
                if (core_digest[128*i +: 128] == target_r) begin
                    match_mask[i] = 1'b1;
                end
            end
        end
        match_first = match_mask & (~match_mask + CORES'(1));
        for (int i = 0; i < CORES; i++) begin
            if (match_first[i]) begin
                match_pick = core_value[128*i +: 128];
            end
        end
        free      = ~pending | complete;
        can_issue = (state == RUN) && !last_issued && !abort && (match_mask == '0);
        issue     = can_issue ? (free & (~free + CORES'(1))) : '0;
        at_limit  = (cnt == limit_r);
    end

    assign core_new_message = issue;
    assign core_message     = (issue != '0) ? {base_hi, cnt} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            target_r    <= '0;
            base_hi     <= '0;
            limit_r     <= '0;
            cnt         <= '0;
            last_issued <= 1'b0;
            pending     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            match_value <= '0;
            tested      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target_r    <= target;
                        base_hi     <= base[127:CNT_W];
                        limit_r     <= limit;
                        cnt         <= '0;
                        tested      <= '0;
                        found       <= 1'b0;
                        match_value <= '0;
                        last_issued <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    pending <= (pending & ~complete) | issue;
                    tested  <= tested + n_complete;
                    if (!found && (match_mask != '0)) begin
                        found       <= 1'b1;
                        match_value <= match_pick;
                    end
                    if (state == RUN) begin
                        // The counter parks on limit so an all-ones limit never wraps back to zero.
                        if (issue != '0) begin
                            if (at_limit) begin
                                last_issued <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        if ((match_mask != '0) || abort || last_issued || ((issue != '0) && at_limit)) begin
                            state <= DRAIN;
                        end
                    end else if (pending == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_crack_sched.sv
// Scoreboard bench for md5_crack_sched: behavioural 64-cycle core models, a queue-based
// expectation model derived from issue timing, and a decoupled output monitor.
module tb_md5_crack_sched;

    localparam int CORES = 4;
    localparam int CNT_W = 8;
    localparam int LAT   = 65;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [127:0]         target;
    logic [127:0]         base;
    logic [CNT_W-1:0]     limit;
    logic                 busy;
    logic                 done;
    logic                 found;
    logic [127:0]         match_value;
    logic [CNT_W:0]       tested;
    logic [127:0]         core_message;
    logic [CORES-1:0]     core_new_message;
    logic [CORES-1:0]     core_valid;
    logic [CORES*128-1:0] core_digest;
    logic [CORES*128-1:0] core_value;

    md5_crack_sched #(.CORES(CORES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .target(target), .base(base), .limit(limit),
        .busy(busy), .done(done), .found(found), .match_value(match_value), .tested(tested),
        .core_message(core_message), .core_new_message(core_new_message),
        .core_valid(core_valid), .core_digest(core_digest), .core_value(core_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] msg;
        int           cyc;
        int           core;
    } strobe_t;

    typedef struct {
        bit           fnd;
        logic [127:0] mv;
        int           tst;
        int           dcyc;
    } res_t;

    strobe_t sbq[$];
    res_t    rq[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      cyc        = 0;
    int      start_edge = 0;
    int      done_count = 0;

    // Stand-in digest: a bijective mix, so distinct candidates never collide.
    function automatic logic [127:0] fake_digest(input logic [127:0] m);
        logic [127:0] d;
        d = (m ^ 128'h5A5A_C3C3_0F0F_9696_A5A5_3C3C_F0F0_6969) * 128'h9E3779B97F4A7C15F39CC0605CEDC835;
        d = d ^ (d >> 67);
        return d;
    endfunction

    function automatic logic [127:0] cand(input logic [127:0] bs, input int j);
        logic [CNT_W-1:0] jj;
        jj = CNT_W'(j);
        return {bs[127:CNT_W], jj};
    endfunction

    // Cycle (counted from the start edge) in which candidate j is strobed when nothing stops issuing.
    function automatic int issue_cycle(input int j);
        return (j / CORES) * LAT + (j % CORES) + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural cores: accept a strobe, present valid 64 edges later, hold until the next strobe.
    logic [127:0] cdig  [CORES];
    logic [127:0] cval  [CORES];
    int           timer [CORES];
    bit           running [CORES];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < CORES; i++) begin
            if (rst) begin
                core_valid[i] <= 1'b0;
                running[i]    <= 1'b0;
                timer[i]      <= 0;
                cdig[i]       <= '0;
                cval[i]       <= '0;
            end else if (core_new_message[i]) begin
                cval[i]       <= core_message;
                core_valid[i] <= 1'b0;
                running[i]    <= 1'b1;
                timer[i]      <= 0;
            end else if (running[i]) begin
                if (timer[i] == 63) begin
                    core_valid[i] <= 1'b1;
                    cdig[i]       <= fake_digest(cval[i]);
                    running[i]    <= 1'b0;
                end
                timer[i] <= timer[i] + 1;
            end
        end
    end

    always_comb begin
        core_digest = '0;
        core_value  = '0;
        for (int i = 0; i < CORES; i++) begin
            core_digest[128*i +: 128] = cdig[i];
            core_value[128*i +: 128]  = cval[i];
        end
    end

    // Monitor: samples well after the falling edge, once stimulus and core models have settled.
    int      mon_n;
    bit      busy_exp;
    strobe_t s_exp;
    res_t    r_exp;

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            mon_n    = cyc - start_edge;
            busy_exp = (rq.size() > 0) && (mon_n >= 1) && (mon_n < rq[0].dcyc);
            checkOutput("busy", busy, busy_exp);
            if (core_new_message != '0) begin
                if (sbq.size() == 0) begin
                    checkOutput("extra_strobe", core_new_message, '0);
                end else begin
                    s_exp = sbq.pop_front();
                    checkOutput("strobe_onehot", $onehot(core_new_message), 1);
                    checkOutput("strobe_core", core_new_message, CORES'(1) << s_exp.core);
                    checkOutput("strobe_msg", core_message, s_exp.msg);
                    checkOutput("strobe_cycle", mon_n, s_exp.cyc);
                end
            end
            if (done) begin
                done_count++;
                if (rq.size() == 0) begin
                    checkOutput("extra_done", done, 1'b0);
                end else begin
                    r_exp = rq.pop_front();
                    checkOutput("found", found, r_exp.fnd);
                    checkOutput("match_value", match_value, r_exp.mv);
                    checkOutput("tested", tested, r_exp.tst);
                    checkOutput("done_cycle", mon_n, r_exp.dcyc);
                end
            end
        end
    end

    task automatic checkResetState();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_found", found, 0);
        checkOutput("rst_match_value", match_value, 0);
        checkOutput("rst_tested", tested, 0);
        checkOutput("rst_core_new_message", core_new_message, 0);
        checkOutput("rst_core_message", core_message, 0);
    endtask

    // Runs one search; abort_at/rst_at are cycles after the start edge (0 = never).
    task automatic applyStimulus(input logic [127:0] tgt, input logic [127:0] bs, input int lim,
                                 input int abort_at, input bit poke_start, input int rst_at);
        int      k;
        int      stop;
        int      issued;
        int      first_done;
        int      waited;
        int      budget;
        res_t    r;
        strobe_t s;

        k = -1;
        for (int j = 0; j <= lim; j++) begin
            if (fake_digest(cand(bs, j)) == tgt) begin
                k = j;
                break;
            end
        end
        stop = 1 << 30;
        if (abort_at > 0) stop = abort_at;
        r.fnd = (k >= 0) && (issue_cycle(k) < stop);
        if (r.fnd && (issue_cycle(k) + LAT < stop)) stop = issue_cycle(k) + LAT;
        issued = 0;
        for (int j = 0; j <= lim; j++) begin
            if (issue_cycle(j) < stop) issued++;
        end
        r.mv   = r.fnd ? cand(bs, k) : '0;
        r.tst  = issued;
        r.dcyc = issue_cycle(issued - 1) + LAT + 2;

        first_done = done_count;
        @(negedge clk);
        target = tgt;
        base   = bs;
        limit  = CNT_W'(lim);
        start  = 1'b1;
        start_edge = cyc;
        for (int j = 0; j < issued; j++) begin
            s.msg  = cand(bs, j);
            s.cyc  = issue_cycle(j);
            s.core = j % CORES;
            sbq.push_back(s);
        end
        rq.push_back(r);
        @(negedge clk);
        start = 1'b0;

        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            if (poke_start) begin
                @(negedge clk);
                target = ~tgt;
                base   = ~bs;
                limit  = '0;
                start  = 1'b1;
                @(negedge clk);
                start  = 1'b0;
            end
        end

        if (rst_at > 0) begin
            repeat (rst_at - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            checkResetState();
            sbq.delete();
            rq.delete();
            @(negedge clk);
            rst = 1'b0;
            return;
        end

        budget = r.dcyc + 20;
        waited = 0;
        while ((done_count == first_done) && (waited < budget)) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        checkOutput("done_count", done_count - first_done, 1);
        checkOutput("strobes_left", sbq.size(), 0);
        if (done_count == first_done) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            sbq.delete();
            rq.delete();
            rst = 1'b0;
        end
    endtask

    logic [127:0] rbase;
    logic [127:0] rtgt;
    int           rlim;
    int           rmode;
    int           rab;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        target = '0; base = '0; limit = '0;
        repeat (3) @(negedge clk);
        checkResetState();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] match mid-range");
        applyStimulus(fake_digest(cand('0, 5)), '0, 20, 0, 1'b0, 0);

        $display("[TB] exhaust without match");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, '0, 7, 0, 1'b0, 0);

        $display("[TB] single candidate");
        rbase = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, rbase, 0, 0, 1'b0, 0);

        $display("[TB] all-ones limit, no counter wrap");
        rbase = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, rbase, (1 << CNT_W) - 1, 0, 1'b0, 0);

        $display("[TB] abort in RUN with ignored start during drain");
        applyStimulus(fake_digest(cand('0, 30)), '0, 60, 10, 1'b1, 0);

        $display("[TB] reset mid-search");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, '0, 100, 0, 1'b0, 30);
        applyStimulus(fake_digest(cand('0, 1)), '0, 50, 0, 1'b0, 70);
        applyStimulus(fake_digest(cand('0, 9)), '0, 12, 0, 1'b0, 0);

        $display("[TB] randomized searches");
        for (int t = 0; t < 10; t++) begin
            rbase = {$urandom, $urandom, $urandom, $urandom};
            rlim  = $urandom_range(0, 40);
            rmode = $urandom_range(0, 2);
            if (rmode == 0)
                rtgt = fake_digest(cand(rbase, $urandom_range(0, rlim)));
            else if (rmode == 1)
                rtgt = fake_digest(cand(rbase, rlim + 1));
            else
                rtgt = {$urandom, $urandom, $urandom, $urandom};
            rab = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 150) : 0;
            applyStimulus(rtgt, rbase, rlim, rab, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
